// File: rtl/uart_mmio_fifo_if.sv
// uart_mmio_fifo_if: SOC IO-page bus bundle for the memory-mapped UART.
//   sel_dat / sel_cntl : register selects (one-hot word-address decode)
//   mem_wstrb          : write strobe
//   mem_rstrb          : read strobe (single cycle)
//   mem_wdata          : write data
//   io_rdata           : registered read data, valid the cycle after mem_rstrb
interface uart_mmio_fifo_if;
  logic        sel_dat;
  logic        sel_cntl;
  logic        mem_wstrb;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [31:0] io_rdata;

  modport master (output sel_dat, sel_cntl, mem_wstrb, mem_rstrb, mem_wdata,
                  input  io_rdata);
  modport slave  (input  sel_dat, sel_cntl, mem_wstrb, mem_rstrb, mem_wdata,
                  output io_rdata);
endinterface

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped full-duplex 8N1 UART with TX/RX FIFOs.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : IO-page register bus (uart_mmio_fifo_if.slave)
//   RXD    : asynchronous serial input
//   TXD    : serial output, idle high
// Registers: DAT  write pushes TX byte, read pops RX byte as {rx_valid, byte}.
//            CNTL read {frame_err[12], overrun[11], tx_idle[10], tx_full[9], rx_valid[8]},
//                 write 1 to bit 11 / bit 12 clears overrun / frame_err.
// Build option: define UART_RX_EN to include the receiver, RX FIFO and error flags;
//   without it RXD is ignored and all RX-related read bits are 0.
module uart_mmio_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 16_000_000,
  parameter int unsigned BAUD_RATE   = 1_000_000,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  uart_mmio_fifo_if.slave   bus,
  input  logic              RXD,
  output logic              TXD
);
  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // CNTL wins a double select, so DAT side effects are masked by sel_cntl.
  logic dat_acc, wr_dat, rd_dat, wr_cntl, rd_cntl;
  assign dat_acc = bus.sel_dat & ~bus.sel_cntl;
  assign wr_dat  = bus.mem_wstrb & dat_acc;
  assign rd_dat  = bus.mem_rstrb & dat_acc;
  assign wr_cntl = bus.mem_wstrb & bus.sel_cntl;
  assign rd_cntl = bus.mem_rstrb & bus.sel_cntl;

  logic       rx_valid, overrun, frame_err;
  logic [7:0] rx_head;

  // ---------------- TX FIFO ----------------
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wp_q, tx_rp_q;
  logic         tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) &&
                    (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
  // Full is judged on the pre-edge state: a same-cycle pop does not make room.
  assign tx_push  = wr_dat & ~tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    if (tx_state_q == S_IDLE) begin
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = tx_mem[tx_rp_q[TAW-1:0]];
        tx_cnt_d   = DIV_M1;
        txd_d      = 1'b0;
        tx_state_d = S_START;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - CW'(1);
    end else begin
      tx_cnt_d = DIV_M1;
      case (tx_state_q)
        S_START: begin
          txd_d      = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[7:1]};
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end
        S_DATA: begin
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
        default: begin
          // End of stop bit: chain straight into the next frame when data is waiting.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_mem[tx_rp_q[TAW-1:0]];
            txd_d      = 1'b0;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  assign TXD = txd_q;

  logic tx_idle;
  assign tx_idle = tx_empty && (tx_state_q == S_IDLE);

`ifdef UART_RX_EN
  localparam int unsigned RAW = $clog2(RX_DEPTH);

  // ---------------- RX synchroniser + FSM ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_push, rx_pop, rx_ovf_set, rx_ferr_set;
  logic          rx_empty, rx_full;
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [RAW:0]  rx_wp_q, rx_rp_q;
  logic          overrun_q, frame_err_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push     = 1'b0;
    rx_ovf_set  = 1'b0;
    rx_ferr_set = 1'b0;
    if (rx_state_q == S_IDLE) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_cnt_d   = HALF_M1;
        rx_state_d = S_START;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - CW'(1);
    end else begin
      rx_cnt_d = DIV_M1;
      case (rx_state_q)
        S_START: begin
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
        default: begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q)     rx_ferr_set = 1'b1;
          else if (rx_full) rx_ovf_set  = 1'b1;
          else              rx_push     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= RXD;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------- RX FIFO + sticky flags ----------------
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) &&
                    (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
  assign rx_pop   = rd_dat & ~rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      // A new error event outranks a clear arriving in the same cycle.
      if (rx_ovf_set)                         overrun_q <= 1'b1;
      else if (wr_cntl && bus.mem_wdata[11])  overrun_q <= 1'b0;
      if (rx_ferr_set)                        frame_err_q <= 1'b1;
      else if (wr_cntl && bus.mem_wdata[12])  frame_err_q <= 1'b0;
    end
  end

  assign rx_valid  = ~rx_empty;
  assign rx_head   = rx_mem[rx_rp_q[RAW-1:0]];
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
`else
  assign rx_valid  = 1'b0;
  assign rx_head   = '0;
  assign overrun   = 1'b0;
  assign frame_err = 1'b0;

  logic unused_rx;
  assign unused_rx = &{1'b0, RXD, bus.mem_wdata[12:11]};
`endif

  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.mem_wdata[31:13], bus.mem_wdata[10:8]};

  // ---------------- Read data register ----------------
  logic [31:0] io_rdata_q, io_rdata_d;

  always_comb begin
    io_rdata_d = io_rdata_q;
    if (rd_cntl)
      io_rdata_d = {19'b0, frame_err, overrun, tx_idle, tx_full, rx_valid, 8'b0};
    else if (rd_dat)
      io_rdata_d = rx_valid ? {23'b0, 1'b1, rx_head} : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) io_rdata_q <= '0;
    else         io_rdata_q <= io_rdata_d;
  end

  assign bus.io_rdata = io_rdata_q;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
module tb_uart_mmio_fifo;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic RXD = 1'b1;
  logic TXD;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] d;
  logic [7:0] pat [10] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h99};

  uart_mmio_fifo_if bus ();

  uart_mmio_fifo #(
    .CLK_FREQ_HZ(16_000_000),
    .BAUD_RATE  (1_000_000),
    .TX_DEPTH   (8),
    .RX_DEPTH   (8)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus),
    .RXD   (RXD),
    .TXD   (TXD)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (vectors %0d, miscompares %0d)", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic dat, input logic cntl, input logic [31:0] wd);
    @(negedge clk);
    bus.sel_dat = dat; bus.sel_cntl = cntl; bus.mem_wstrb = 1'b1; bus.mem_wdata = wd;
    @(posedge clk); #1;
    bus.sel_dat = 1'b0; bus.sel_cntl = 1'b0; bus.mem_wstrb = 1'b0; bus.mem_wdata = '0;
  endtask

  task automatic bus_rd(input logic dat, input logic cntl, output logic [31:0] rd);
    @(negedge clk);
    bus.sel_dat = dat; bus.sel_cntl = cntl; bus.mem_rstrb = 1'b1;
    @(posedge clk); #1;
    bus.sel_dat = 1'b0; bus.sel_cntl = 1'b0; bus.mem_rstrb = 1'b0;
    rd = bus.io_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Entered at the start-bit centre (+1ns), or at the bit-0 centre when skip_start is set.
  // Leaves at the stop-bit centre (+1ns).
  task automatic check_frame(input logic [7:0] b, input logic skip_start);
    if (!skip_start) check("tx_start", TXD, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0 || !skip_start) begin repeat (16) @(posedge clk); #1; end
      check($sformatf("tx_bit%0d", i), TXD, {31'b0, b[i]});
    end
    repeat (16) @(posedge clk); #1;
    check("tx_stop", TXD, 32'h1);
  endtask

  // n back-to-back DAT writes into an empty FIFO with the shifter idle.
  task automatic tx_burst(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) bus_wr(1'b1, 1'b0, {24'b0, pat[i]});
    bus_rd(1'b0, 1'b1, r);
    check($sformatf("burst%0d_full", n), r, 32'h200);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin repeat (16) @(posedge clk); #1; end
      check_frame(pat[k], 1'b0);
    end
    repeat (16 - n) @(posedge clk); #1;
    bus_rd(1'b0, 1'b1, r);
    check($sformatf("burst%0d_in_stop", n), r, 32'h0);
    bus_rd(1'b0, 1'b1, r);
    check($sformatf("burst%0d_idle", n), r, 32'h400);
    repeat (20) @(posedge clk); #1;
    check($sformatf("burst%0d_line_idle", n), TXD, 32'h1);
  endtask

`ifdef UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk); RXD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (16) @(negedge clk);
    end
    RXD = stop;
    repeat (16) @(negedge clk);
    RXD = 1'b1;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    bus.sel_dat = 1'b0; bus.sel_cntl = 1'b0;
    bus.mem_wstrb = 1'b0; bus.mem_rstrb = 1'b0; bus.mem_wdata = '0;
    do_reset();
    @(posedge clk); #1;
    check("rst_txd", TXD, 32'h1);
    check("rst_rdata", bus.io_rdata, 32'h0);
    bus_rd(1'b0, 1'b1, d);
    check("rst_cntl", d, 32'h400);

    // Single frame 0x41 with exact start-bit edges.
    bus_wr(1'b1, 1'b0, 32'h41);
    check("tx_pre", TXD, 32'h1);
    @(posedge clk); #1;
    check("tx_start_edge", TXD, 32'h0);
    repeat (15) @(posedge clk); #1;
    check("tx_start_last", TXD, 32'h0);
    @(posedge clk); #1;
    check("tx_bit0_edge", TXD, 32'h1);
    repeat (8) @(posedge clk); #1;
    check_frame(8'h41, 1'b1);
    repeat (7) @(posedge clk); #1;
    bus_rd(1'b0, 1'b1, d);
    check("f41_in_stop", d, 32'h0);
    bus_rd(1'b0, 1'b1, d);
    check("f41_idle", d, 32'h400);

    // Read data holds without a selected read.
    bus_rd(1'b0, 1'b0, d);
    check("rd_hold_nosel", d, 32'h400);
    repeat (5) @(posedge clk); #1;
    check("rd_hold_idle", bus.io_rdata, 32'h400);

    tx_burst(9);
    tx_burst(10);

    // Double select: CNTL wins, no TX push.
    bus_wr(1'b1, 1'b1, 32'h55);
    repeat (4) @(posedge clk); #1;
    check("both_wr_txd", TXD, 32'h1);
    bus_rd(1'b1, 1'b1, d);
    check("both_rd", d, 32'h400);

    // Empty DAT read returns 0.
    bus_rd(1'b1, 1'b0, d);
    check("dat_rd_empty", d, 32'h0);

`ifdef UART_RX_EN
    send_rx(8'h5A, 1'b1);
    bus_rd(1'b0, 1'b1, d);
    check("rx_valid", d, 32'h500);
    bus_rd(1'b1, 1'b0, d);
    check("rx_dat_5a", d, 32'h15A);
    bus_rd(1'b1, 1'b0, d);
    check("rx_dat_empty", d, 32'h0);

    @(negedge clk); RXD = 1'b0;
    repeat (4) @(negedge clk);
    RXD = 1'b1;
    repeat (40) @(negedge clk);
    bus_rd(1'b0, 1'b1, d);
    check("rx_glitch", d, 32'h400);

    send_rx(8'h33, 1'b0);
    bus_rd(1'b0, 1'b1, d);
    check("rx_ferr", d, 32'h1400);
    bus_rd(1'b1, 1'b0, d);
    check("rx_ferr_nobyte", d, 32'h0);
    bus_wr(1'b0, 1'b1, 32'h1000);
    bus_rd(1'b0, 1'b1, d);
    check("rx_ferr_clr", d, 32'h400);

    for (int i = 0; i < 9; i++) send_rx(pat[i], 1'b1);
    bus_rd(1'b0, 1'b1, d);
    check("rx_ovr", d, 32'hD00);
    for (int i = 0; i < 8; i++) begin
      bus_rd(1'b1, 1'b0, d);
      check($sformatf("rx_ovr_byte%0d", i), d, {23'b0, 1'b1, pat[i]});
    end
    bus_rd(1'b1, 1'b0, d);
    check("rx_ovr_drained", d, 32'h0);
    bus_wr(1'b0, 1'b1, 32'h800);
    bus_rd(1'b0, 1'b1, d);
    check("rx_ovr_clr", d, 32'h400);
`else
    bus_wr(1'b0, 1'b1, 32'h1800);
    bus_rd(1'b0, 1'b1, d);
    check("norx_cntl", d, 32'h400);
`endif

    // Reset mid-frame with a second byte queued.
    bus_wr(1'b1, 1'b0, 32'h00);
    bus_wr(1'b1, 1'b0, 32'hF0);
    repeat (40) @(posedge clk); #1;
    check("mid_frame_low", TXD, 32'h0);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_txd", TXD, 32'h1);
    check("rst_mid_rdata", bus.io_rdata, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("rst_flushed_txd", TXD, 32'h1);
    bus_rd(1'b0, 1'b1, d);
    check("rst_mid_cntl", d, 32'h400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
